pipelined_shifter: RTL and testbench
====================================

# pipelined_shifter

Parametrised, pipelined barrel shift/rotate unit with a valid/ready handshake, replacing the fixed 16-bit combinational rotate-right in the datapath. It supports five operations (rotate right/left, logical left/right, arithmetic right) on a power-of-two word width. It adds carry and zero flags and a sideband tag, and tolerates downstream backpressure without data loss. It sits between the operand-fetch stage and write-back of the processing core.

## Interface
- `WIDTH`, 16: data width; power of two, ≥4.
- `TAG_W`, 4: sideband tag width, carried unmodified with each word.
- `SHW`, `$clog2(WIDTH)`: derived shift-amount width; also the pipeline depth.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  input word is present.
- `in_ready`  out  1  unit accepts the input this cycle.
- `in_data`  in  WIDTH  operand.
- `in_amt`  in  SHW  shift/rotate amount, 0..WIDTH-1.
- `in_op`  in  3  operation: 000 ROR, 001 ROL, 010 SLL, 011 SRL, 100 SRA, 101–111 reserved.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  result is present.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  WIDTH  result.
- `out_carry`  out  1  last bit shifted or rotated off.
- `out_zero`  out  1  `out_data == 0`.
- `out_tag`  out  TAG_W  tag of this result.

## Operation
- **Transfers.** Input transfer occurs when `in_valid && in_ready`; output transfer occurs when `out_valid && out_ready`.
- **Pipeline.** The pipeline has SHW stages. Stage k shifts by 2^k when `amt[k]` is set, otherwise passes the word through. Each stage is followed by a register holding valid, data, remaining amount, op, tag and carry.
- **Left operations (ROL, SLL).** Stage 0 input is bit-reversed. The matching right operation (ROR, SRL) is applied. The final stage output is bit-reversed back. SRA is never reversed.
- **Fill bits per stage.**
  - ROR: the rotated-off bits.
  - SRL and reversed SLL: zeros.
  - SRA: the sign bit of the original operand.
- **Carry.** Cleared on entry. Each active stage sets carry to the highest bit it discards, i.e. bit 2^k−1 of its input (reversed domain for left ops). The result is:
  - ROR, SRL, SRA by n: `in_data[n-1]`.
  - ROL, SLL by n: `in_data[WIDTH-n]`.
  - n=0: carry is 0.
- **Zero flag.** `out_zero` is computed from the final result (combinationally from the output register, or registered alongside it).
- **Reserved ops.** The word passes unmodified, with carry 0 and zero flag computed normally.
- **Flow control.** The pipeline uses a global stall: `stall = out_valid && !out_ready`.
  - `in_ready = !stall`.
  - When stalled, no register changes.
  - When not stalled, all stages advance one step; bubbles advance too.
- **Ordering.** Order is preserved. There is no reordering, dropping or duplication.
- **Reset.** The `rst` edge clears every valid bit and data, carry and tag registers. `out_valid`, `out_data`, `out_carry` and `out_tag` are 0 and `out_zero` is 1 in the cycle after reset. Words in flight at reset are discarded.

## Timing
- Latency is SHW cycles (4 for WIDTH=16) from input transfer to `out_valid` when there is no stall.
- Throughput is one word per cycle when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready`; this is the only combinational input-to-output path.
- Simultaneous input and output transfer in a cycle is legal and is the steady state.
- When `out_ready` deasserts, `in_ready` drops in the same cycle. The output holds stable and all values stay constant until `out_ready` returns.
- `in_amt` values ≥ WIDTH cannot occur, because the port width is SHW.

## Structure
- Shared package `shifter_pkg`:
  - op encodings (`OP_ROR`, `OP_ROL`, `OP_SLL`, `OP_SRL`, `OP_SRA`);
  - the per-stage payload struct (data, amt, op, tag, carry, sign).
- One sub-module, `shift_stage`, parametrised by stage index k: combinational 2^k shift/rotate plus its enable-gated pipeline register. It is instantiated SHW times in a generate loop.
- The top level contains the reversal logic, stall generation and zero flag.

## Test plan
- ROR `0x1234` by 4 → `0x4123`, carry 0, zero 0; `out_valid` exactly 4 cycles after the transfer.
- ROL `0x8001` by 1 → `0x0003`, carry 1; SLL `0x00FF` by 9 → `0xFE00`, carry 1.
- SRA `0x8000` by 15 → `0xFFFF`, carry 0; SRL `0x8000` by 15 → `0x0001`; SRL `0x0001` by 1 → `0x0000`, carry 1, zero 1.
- Amount 0 for every op on `0xA5A5` → `0xA5A5`, carry 0; reserved op 101 by 7 → `0xA5A5`, carry 0.
- Six back-to-back inputs with tags 0–5, with `out_ready` low for 3 cycles mid-stream:
  - `in_ready` is low exactly during the stall;
  - all six results arrive in tag order;
  - the output is stable while stalled.
- Assert `rst` with 3 words in flight → next cycle `out_valid`=0 and all outputs at reset values; no stale word emerges later.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shift/rotate unit: operation
// encodings, the control part of the per-stage payload, and a helper that
// identifies the operations that run in the bit-reversed domain.
package shifter_pkg;

    // Encodings 3'b101..3'b111 are reserved and pass the word through.
    typedef enum logic [2:0] {
        OP_ROR = 3'b000,
        OP_ROL = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } shift_op_e;

    // Control fields that travel with every word through the stages.
    typedef struct packed {
        logic [2:0] op;     // raw op code, reserved values included
        logic       carry;  // last bit discarded so far
        logic       sign;   // MSB of the original operand, SRA fill
    } stage_ctrl_t;

    // Left operations are executed as their right-hand twins on a
    // bit-reversed word.
    function automatic logic is_left_op(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: conditionally shifts/rotates
// the word right by 2^K and registers the full payload. Left operations
// arrive already bit-reversed, so only right-hand shifts exist here.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int SHW   = $clog2(WIDTH),
    parameter int K     = 0,
    parameter int PL_W  = WIDTH + SHW + TAG_W + $bits(stage_ctrl_t)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [PL_W-1:0] in_pl,
    output logic            out_valid,
    output logic [PL_W-1:0] out_pl
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        logic [TAG_W-1:0] tag;
        stage_ctrl_t      ctrl;
    } payload_t;

    localparam int S = 1 << K;

    payload_t cur;
    payload_t nxt;

    assign cur = in_pl;

    // Shift by 2^K when this stage's amount bit is set; carry takes the
    // highest discarded bit, which is bit S-1 of the stage input.
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no
        // path through the case below can leave a latch behind.
        nxt = cur;
        if (cur.amt[K]) begin
            case (cur.ctrl.op)
                OP_ROR, OP_ROL: begin
                    nxt.data       = (cur.data >> S) | (cur.data << (WIDTH - S));
                    nxt.ctrl.carry = cur.data[S-1];
                end
                OP_SRL, OP_SLL: begin
                    nxt.data       = cur.data >> S;
                    nxt.ctrl.carry = cur.data[S-1];
                end
                OP_SRA: begin
                    nxt.data       = (cur.data >> S) | ({WIDTH{cur.ctrl.sign}} << (WIDTH - S));
                    nxt.ctrl.carry = cur.data[S-1];
                end
                default: nxt = cur;
            endcase
        end
    end

    // Stage register: frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // stage samples its neighbour's pre-edge value.
        if (rst) begin
            // NOTE: payload is reset too, not just valid, because the final
            // stage drives the output ports and they must read 0 after reset.
            out_valid <= 1'b0;
            out_pl    <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_pl    <= nxt;
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shift/rotate unit with valid/ready flow control.
// SHW stages, one per amount bit; left operations are bit-reversed on
// entry and exit; a global stall freezes every stage under backpressure.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        logic [TAG_W-1:0] tag;
        stage_ctrl_t      ctrl;
    } payload_t;

    localparam int PL_W = $bits(payload_t);

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    logic [SHW:0]    stage_valid;
    logic [PL_W-1:0] stage_pl [SHW+1];
    payload_t        entry;
    payload_t        tail;
    logic            stall;
    logic            advance;
    logic            unused_tail;

    // Build the stage-0 payload; left ops enter the reversed domain here.
    always_comb begin
        entry            = '0;
        entry.data       = is_left_op(in_op) ? bit_rev(in_data) : in_data;
        entry.amt        = in_amt;
        entry.tag        = in_tag;
        entry.ctrl.op    = in_op;
        entry.ctrl.carry = 1'b0;
        entry.ctrl.sign  = in_data[WIDTH-1];
    end

    assign stage_valid[0] = in_valid;
    assign stage_pl[0]    = entry;

    // Only a held, unaccepted result stops the pipe; bubbles advance.
    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .SHW   (SHW),
            .K     (k),
            .PL_W  (PL_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (stage_valid[k]),
            .in_pl     (stage_pl[k]),
            .out_valid (stage_valid[k+1]),
            .out_pl    (stage_pl[k+1])
        );
    end

    assign tail      = stage_pl[SHW];
    assign out_valid = stage_valid[SHW];
    assign out_carry = tail.ctrl.carry;
    assign out_tag   = tail.tag;

    // Leave the reversed domain and flag an all-zero result.
    always_comb begin
        out_data = is_left_op(tail.ctrl.op) ? bit_rev(tail.data) : tail.data;
        out_zero = (out_data == '0);
    end

    // Remaining amount and sign are spent by the last stage.
    assign unused_tail = ^{tail.amt, tail.ctrl.sign};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=16): an arithmetic
// reference model feeds a scoreboard checked on every output transfer,
// plus per-cycle flow-control and hold-stability checks.
module tb_pipelined_shifter;

    localparam int W  = 16;
    localparam int TW = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_amt;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          out_zero;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {carry, result} straight from the operation definitions.
    function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] d, input int n);
        logic [W-1:0]        r;
        logic signed [W-1:0] sd;
        logic                c;
        sd = d;
        r  = d;
        c  = 1'b0;
        if (n != 0) begin
            case (op)
                3'b000: begin r = (d >> n) | (d << (W - n)); c = d[n-1]; end
                3'b001: begin r = (d << n) | (d >> (W - n)); c = d[W-n]; end
                3'b010: begin r = d << n;                    c = d[W-n]; end
                3'b011: begin r = d >> n;                    c = d[n-1]; end
                3'b100: begin r = sd >>> n;                  c = d[n-1]; end
                default: begin r = d; c = 1'b0; end
            endcase
        end
        return {c, r};
    endfunction

    typedef struct {
        logic [W-1:0]  data;
        logic          carry;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   out_count    = 0;
    int   stall_cycles = 0;
    logic prev_stall   = 1'b0;
    logic          prev_valid;
    logic [W-1:0]  prev_data;
    logic          prev_carry;
    logic          prev_zero;
    logic [TW-1:0] prev_tag;

    // Compare process: flow control, hold stability and scoreboard.
    always @(negedge clk) begin
        logic [W:0] m;
        exp_t       e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (!in_ready) stall_cycles++;
            if (prev_stall) begin
                check("hold_valid", out_valid, prev_valid);
                check("hold_data",  out_data,  prev_data);
                check("hold_carry", out_carry, prev_carry);
                check("hold_zero",  out_zero,  prev_zero);
                check("hold_tag",   out_tag,   prev_tag);
            end
            if (out_valid && out_ready) begin
                out_count++;
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_data",  out_data,  e.data);
                    check("out_carry", out_carry, e.carry);
                    check("out_zero",  out_zero,  e.data == '0);
                    check("out_tag",   out_tag,   e.tag);
                end
            end
            if (in_valid && in_ready) begin
                m      = model(in_op, in_data, int'(in_amt));
                e.data = m[W-1:0];
                e.carry = m[W];
                e.tag  = in_tag;
                sb.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_carry = out_carry;
            prev_zero  = out_zero;
            prev_tag   = out_tag;
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] d, input int n, input logic [TW-1:0] tag);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = SW'(n);
        in_tag   = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        check("send_accepted", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_carry"}, out_carry, 0);
        check({tag, "_out_tag"},   out_tag,   0);
        check({tag, "_out_zero"},  out_zero,  1);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] d;
        int           n;
    } vec_t;

    vec_t vecs[$] = '{
        '{3'b000, 16'h1234, 4},  '{3'b001, 16'h8001, 1},  '{3'b010, 16'h00FF, 9},
        '{3'b100, 16'h8000, 15}, '{3'b011, 16'h8000, 15}, '{3'b011, 16'h0001, 1},
        '{3'b000, 16'hA5A5, 0},  '{3'b001, 16'hA5A5, 0},  '{3'b010, 16'hA5A5, 0},
        '{3'b011, 16'hA5A5, 0},  '{3'b100, 16'hA5A5, 0},  '{3'b101, 16'hA5A5, 7},
        '{3'b110, 16'h0000, 3},  '{3'b111, 16'h5A5A, 15}, '{3'b100, 16'h7F00, 3},
        '{3'b001, 16'h1234, 12}, '{3'b010, 16'h0001, 15}, '{3'b000, 16'h0001, 1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        logic [W:0] m;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        // Pin the reference model to hand-computed results.
        m = model(3'b000, 16'h1234, 4);  check("model_ror", m, {1'b0, 16'h4123});
        m = model(3'b001, 16'h8001, 1);  check("model_rol", m, {1'b1, 16'h0003});
        m = model(3'b010, 16'h00FF, 9);  check("model_sll", m, {1'b1, 16'hFE00});
        m = model(3'b100, 16'h8000, 15); check("model_sra", m, {1'b0, 16'hFFFF});
        m = model(3'b011, 16'h8000, 15); check("model_srl15", m, {1'b0, 16'h0001});
        m = model(3'b011, 16'h0001, 1);  check("model_srl1", m, {1'b1, 16'h0000});
        m = model(3'b101, 16'hA5A5, 7);  check("model_rsvd", m, {1'b0, 16'hA5A5});
        m = model(3'b010, 16'hA5A5, 0);  check("model_amt0", m, {1'b0, 16'hA5A5});

        // Latency of a lone ROR, counted in edges including the transfer edge.
        send(3'b000, 16'h1234, 4, 4'h1);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 4);
        check("lat_data", out_data, 16'h4123);
        drain();

        // Directed vectors back to back.
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].op, vecs[i].d, vecs[i].n, TW'(i));
        end
        drain();

        // Six words with a three-cycle downstream stall mid-stream.
        repeat (2) @(posedge clk);
        #1;
        stall_cycles = 0;
        snap = out_count;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(3'(i % 5), 16'h1357 + 16'(i * 16'h1111), i + 1, TW'(i));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", stall_cycles, 3);
        check("stall_outputs", out_count - snap, 6);

        // Reset with three words in flight.
        send(3'b000, 16'hBEEF, 1, 4'hA);
        send(3'b011, 16'hF00F, 2, 4'hB);
        send(3'b001, 16'h0FF0, 3, 4'hC);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("flight_rst");
        sb.delete();
        rst = 1'b0;
        snap = out_count;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale", out_count - snap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
